// File: rtl/map_dec_pkg.sv
// -----------------------------------------------------------------------------
// map_dec_pkg
// Shared definitions for the MAP decoder recursion controllers.
// Holds the controller state encoding and the default memory/datapath
// latency, so the alpha controller and a later beta controller agree on both.
// -----------------------------------------------------------------------------
package map_dec_pkg;

    // Default cycles from an alpha read to valid new metrics at the write
    // port: SRAM read + adder + compare.
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/alpha_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alpha_seq_ctrl
// Sequencer for the forward (alpha) recursion of a MAP decoder. For every
// trellis stage k it reads alpha[k], waits for the metric datapath, then
// writes alpha[k+1]. A run starts with one INIT write of the initial state
// metrics to address 0 and ends with a one-cycle done pulse.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle run request (accepted only in IDLE)
//   frame_len  in   number of trellis stages, sampled on accepted start
//   abort      in   drop the current run, return to IDLE without done
//   ad_addr    out  alpha memory address
//   w_r        out  alpha memory write (1) / read (0)
//   init_en    out  selects initial metrics onto memory write data
//   gamma_addr out  branch-metric stage index
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at run completion
// -----------------------------------------------------------------------------
module alpha_seq_ctrl
    import map_dec_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic              abort,
    output logic [ADDR_W-1:0] ad_addr,
    output logic              w_r,
    output logic              init_en,
    output logic [ADDR_W-1:0] gamma_addr,
    output logic              busy,
    output logic              done
);

    // Last value of the wait counter before moving to WRITE; WAIT lasts
    // PIPE_LAT-1 cycles. Unused when PIPE_LAT==1 (WAIT is skipped).
    localparam logic [3:0] WAIT_LAST = (PIPE_LAT > 1) ? 4'(PIPE_LAT - 2) : 4'd0;

    seq_state_t        r_state, w_nxt_state;
    logic [ADDR_W-1:0] r_k, w_nxt_k;
    logic [ADDR_W-1:0] r_len, w_nxt_len;
    logic [3:0]        r_wcnt, w_nxt_wcnt;

    logic [ADDR_W-1:0] r_ad_addr, w_nxt_ad_addr;
    logic [ADDR_W-1:0] r_gamma_addr, w_nxt_gamma_addr;
    logic              r_w_r, w_nxt_w_r;
    logic              r_init_en, w_nxt_init_en;
    logic              r_busy, w_nxt_busy;
    logic              r_done, w_nxt_done;

    // One bit wider so k+1 == len is exact even at len = 2^ADDR_W-1.
    logic [ADDR_W:0]   w_k_inc;
    assign w_k_inc = {1'b0, r_k} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_k     = r_k;
        w_nxt_len   = r_len;
        w_nxt_wcnt  = r_wcnt;

        unique case (r_state)
            ST_IDLE: begin
                // abort takes priority over start while idle
                if (start && !abort) begin
                    w_nxt_len   = frame_len;
                    w_nxt_k     = '0;
                    w_nxt_state = ST_INIT;
                end
            end
            ST_INIT:  w_nxt_state = (r_len != '0) ? ST_READ : ST_DONE;
            ST_READ: begin
                w_nxt_wcnt  = 4'd0;
                w_nxt_state = (PIPE_LAT == 1) ? ST_WRITE : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wcnt == WAIT_LAST) w_nxt_state = ST_WRITE;
                else                     w_nxt_wcnt  = r_wcnt + 4'd1;
            end
            ST_WRITE: begin
                if (w_k_inc == {1'b0, r_len}) begin
                    w_nxt_state = ST_DONE;
                end else begin
                    w_nxt_k     = w_k_inc[ADDR_W-1:0];
                    w_nxt_state = ST_READ;
                end
            end
            ST_DONE:  w_nxt_state = ST_IDLE;
            default:  w_nxt_state = ST_IDLE;
        endcase

        if (abort && (r_state != ST_IDLE)) w_nxt_state = ST_IDLE;

        // Outputs are decoded from the next state and registered with it,
        // so they change on the same edge as the state.
        w_nxt_ad_addr    = '0;
        w_nxt_gamma_addr = '0;
        w_nxt_w_r        = 1'b0;
        w_nxt_init_en    = 1'b0;
        w_nxt_busy       = (w_nxt_state != ST_IDLE);
        w_nxt_done       = 1'b0;

        unique case (w_nxt_state)
            ST_INIT: begin
                w_nxt_w_r     = 1'b1;
                w_nxt_init_en = 1'b1;
            end
            ST_READ, ST_WAIT: begin
                w_nxt_ad_addr    = w_nxt_k;
                w_nxt_gamma_addr = w_nxt_k;
            end
            ST_WRITE: begin
                // WRITE is only entered from READ/WAIT, where k is unchanged,
                // so k+1 is the current incrementer output.
                w_nxt_ad_addr    = w_k_inc[ADDR_W-1:0];
                w_nxt_gamma_addr = r_k;
                w_nxt_w_r        = 1'b1;
            end
            ST_DONE:  w_nxt_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_len        <= '0;
            r_wcnt       <= 4'd0;
            r_ad_addr    <= '0;
            r_gamma_addr <= '0;
            r_w_r        <= 1'b0;
            r_init_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_k          <= w_nxt_k;
            r_len        <= w_nxt_len;
            r_wcnt       <= w_nxt_wcnt;
            r_ad_addr    <= w_nxt_ad_addr;
            r_gamma_addr <= w_nxt_gamma_addr;
            r_w_r        <= w_nxt_w_r;
            r_init_en    <= w_nxt_init_en;
            r_busy       <= w_nxt_busy;
            r_done       <= w_nxt_done;
        end
    end

    assign ad_addr    = r_ad_addr;
    assign gamma_addr = r_gamma_addr;
    assign w_r        = r_w_r;
    assign init_en    = r_init_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_alpha_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alpha_seq_ctrl
// Bench for alpha_seq_ctrl (ADDR_W=8, PIPE_LAT=3). The expected outputs for
// each cycle of a run are derived arithmetically from the cycle offset since
// start and the run length: cycle 1 is INIT, then each stage occupies
// PIPE_LAT+1 cycles (read, waits, write), and the done pulse follows.
// -----------------------------------------------------------------------------
module tb_alpha_seq_ctrl;

    localparam int AW = 8;
    localparam int P  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] frame_len = '0;
    logic [AW-1:0] ad_addr;
    logic [AW-1:0] gamma_addr;
    logic          w_r;
    logic          init_en;
    logic          busy;
    logic          done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alpha_seq_ctrl #(.ADDR_W(AW), .PIPE_LAT(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .abort      (abort),
        .ad_addr    (ad_addr),
        .w_r        (w_r),
        .init_en    (init_en),
        .gamma_addr (gamma_addr),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs at cycle c after the accepting edge of a run of L
    // stages; c beyond the done cycle (or c<=0) means idle.
    task automatic chk_at(input string tag, input int c, input int L);
        int T, s, ph;
        int e_addr, e_gamma, e_wr, e_init, e_busy, e_done;
        T = 2 + L * (P + 1);
        e_addr = 0; e_gamma = 0; e_wr = 0; e_init = 0; e_busy = 0; e_done = 0;
        if (c == 1) begin
            e_wr = 1; e_init = 1; e_busy = 1;
        end else if (c >= 2 && c < T) begin
            s  = (c - 2) / (P + 1);
            ph = (c - 2) % (P + 1);
            e_busy  = 1;
            e_gamma = s;
            if (ph == P) begin
                e_wr   = 1;
                e_addr = s + 1;
            end else begin
                e_addr = s;
            end
        end else if (c == T) begin
            e_busy = 1; e_done = 1;
        end
        chk({tag, ".ad_addr"},    32'(ad_addr),    32'(e_addr & 8'hFF));
        chk({tag, ".gamma_addr"}, 32'(gamma_addr), 32'(e_gamma & 8'hFF));
        chk({tag, ".w_r"},        32'(w_r),        32'(e_wr));
        chk({tag, ".init_en"},    32'(init_en),    32'(e_init));
        chk({tag, ".busy"},       32'(busy),       32'(e_busy));
        chk({tag, ".done"},       32'(done),       32'(e_done));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run of L stages. abort_at: cycle at which abort is driven (0=never).
    // rst_at: cycle at which rst is pulsed asynchronously (0=never).
    // noise: re-pulse start with random frame_len while the run is busy.
    task automatic do_run(input string tag, input int L, input int abort_at,
                          input int rst_at, input bit noise);
        int T;
        T = 2 + L * (P + 1);
        start     = 1'b1;
        frame_len = AW'(L);
        step();
        start     = 1'b0;
        frame_len = AW'($urandom);
        for (int c = 1; c <= T + 1; c++) begin
            if (abort_at != 0 && c == abort_at + 1) begin
                start = 1'b0;
                abort = 1'b0;
                chk_at({tag, ".aborted"}, 0, L);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk_at({tag, ".post_abort"}, 0, L);
                end
                return;
            end
            chk_at(tag, c, L);
            if (rst_at != 0 && c == rst_at) begin
                #2 rst = 1'b1;
                #1 chk_at({tag, ".async_rst"}, 0, L);
                step();
                chk_at({tag, ".in_rst"}, 0, L);
                rst = 1'b0;
                return;
            end
            abort = (c == abort_at);
            if (noise && c <= T) begin
                start     = 1'($urandom_range(0, 1));
                frame_len = AW'($urandom);
            end
            if (c <= T) step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // reset state
        #2 rst = 1'b1;
        #1 chk_at("reset", 0, 0);
        step();
        step();
        chk_at("reset_hold", 0, 0);
        rst = 1'b0;
        step();
        chk_at("idle", 0, 0);

        // basic 4-stage run and empty run
        do_run("len4", 4, 0, 0, 1'b0);
        do_run("len0", 0, 0, 0, 1'b0);

        // start/frame_len activity while busy must not disturb the run
        do_run("len4_restart", 4, 0, 0, 1'b1);

        // abort in the first cycle of the second stage's WAIT
        do_run("abort_wait2", 4, 7, 0, 1'b0);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1; frame_len = 8'd5;
        step();
        start = 1'b0; abort = 1'b0;
        chk_at("abort_prio", 0, 0);

        // randomized runs, some aborted
        for (int r = 0; r < 10; r++) begin
            int L, ab;
            L  = int'($urandom_range(0, 10));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 + L * (P + 1))) : 0;
            do_run("rand", L, ab, 0, 1'b1);
            step();
            chk_at("rand_gap", 0, 0);
        end

        // maximum length: last write to address 255
        do_run("len255", 255, 0, 0, 1'b0);

        // asynchronous reset in the first WRITE, then a fresh start
        do_run("rst_write", 2, 0, 5, 1'b0);
        do_run("after_rst", 3, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
